move_sequencer: RTL

Turn-and-commit controller for the chess game logic. Accepts one move request at a time from the input/cursor logic and drives the move onto the legality checker. Waits a fixed settle window for the checker's allow flag, then either commits the move into the registered board state and flips the side to move, or rejects it. It owns the authoritative 256-bit board register that feeds the checker and the VGA renderer.

---
 rtl/move_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// Turn-and-commit controller: accepts one move, waits CHECK_WAIT cycles for the checker,
// then commits it into the board register or rejects it. Optional macro: MOVE_SEQ_TURN_CHECK_EN.
module move_sequencer #(
  parameter int unsigned  CHECK_WAIT = 2,
  // Squares 0-7 black back rank, 8-15 black pawns, 48-55 white pawns, 56-63 white back rank
  parameter logic [255:0] INIT_BOARD =
    256'h42365324_11111111_00000000_00000000_00000000_00000000_99999999_CABEDBAC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         moveReq,
  input  logic [13:0]  moveIn,
  input  logic         allowMove,
  output logic         moveReady,
  output logic [13:0]  checkMoveData,
  output logic [255:0] boardOutput,
  output logic         turn,
  output logic         moveDone,
  output logic         moveOk
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t       state_reg, state_next;
  logic [3:0]   count_reg, count_next;
  logic [13:0]  move_reg, move_next;
  logic [255:0] board_reg, board_next;
  logic         turn_reg, turn_next;
  logic         done_reg, done_next;
  logic         ok_reg, ok_next;

  logic [5:0]   src_sq, tgt_sq;
  logic [3:0]   src_piece;
  logic         turn_match;
  logic         commit;

  assign src_sq    = move_reg[11:6];
  assign tgt_sq    = move_reg[5:0];
  assign src_piece = board_reg[{src_sq, 2'b00} +: 4];

`ifdef MOVE_SEQ_TURN_CHECK_EN
  assign turn_match = (src_piece[3] == turn_reg);
`else
  assign turn_match = 1'b1;
`endif

  assign commit = allowMove && (src_piece != 4'b0000) && (src_sq != tgt_sq) && turn_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
      move_reg  <= 14'd0;
      board_reg <= INIT_BOARD;
      turn_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ok_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      move_reg  <= move_next;
      board_reg <= board_next;
      turn_reg  <= turn_next;
      done_reg  <= done_next;
      ok_reg    <= ok_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    move_next  = move_reg;
    board_next = board_reg;
    turn_next  = turn_reg;
    done_next  = 1'b0;
    ok_next    = ok_reg;
    unique case (state_reg)
      IDLE: begin
        if (moveReq) begin
          move_next  = moveIn;
          count_next = 4'(CHECK_WAIT);
          state_next = CHECK;
        end
      end
      CHECK: begin
        count_next = count_reg - 4'd1;
        // Last settle cycle: the checker's answer is only trusted here
        if (count_reg == 4'd1) begin
          state_next = DONE;
          done_next  = 1'b1;
          ok_next    = commit;
          if (commit) begin
            board_next[{tgt_sq, 2'b00} +: 4] = src_piece;
            board_next[{src_sq, 2'b00} +: 4] = 4'b0000;
            turn_next = ~turn_reg;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign moveReady     = (state_reg == IDLE);
  assign checkMoveData = move_reg;
  assign boardOutput   = board_reg;
  assign turn          = turn_reg;
  assign moveDone      = done_reg;
  assign moveOk        = ok_reg;

endmodule
